// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state encoding and widths for the Booth multiplier and its dispatcher
package mul_pkg;

   localparam int MUL_WIDTH  = 8;
   localparam int MUL_PWIDTH = 2 * MUL_WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      HOLD
   } mul_state_t;

endpackage

// File: rtl/operand_fifo.sv
// rtl/operand_fifo.sv - synchronous operand-pair FIFO with count-based full/empty flags
module operand_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   // Flags come from the registered count only: a pop never frees a slot for a push in the same cycle.
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + 1'b1;
         end
         if (do_pop) begin
            rptr <= rptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (!do_push && do_pop) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/mul_dispatch.sv
// rtl/mul_dispatch.sv - queues signed operand pairs, issues them to mul one at a time, returns products
module mul_dispatch
   import mul_pkg::*;
#(
   parameter int WIDTH   = MUL_WIDTH,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_x,
   input  logic [WIDTH-1:0]     in_y,
   output logic                 mul_start,
   output logic [WIDTH-1:0]     mul_x,
   output logic [WIDTH-1:0]     mul_y,
   input  logic [2*WIDTH-1:0]   mul_z,
   input  logic                 mul_valid,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_z,
   output logic                 out_err
);

   localparam int PW  = 2 * WIDTH;
   localparam int WCW = $clog2(TIMEOUT);
   localparam logic [WCW-1:0] WLAST = WCW'(TIMEOUT - 1);

   mul_state_t     state;
   logic [WCW-1:0] wcnt;
   logic           full;
   logic           empty;
   logic           push;
   logic           pop;
   logic [PW-1:0]  head;

   assign in_ready = !full;
   assign push     = in_valid && in_ready;
   assign pop      = (state == IDLE) && !empty;

   operand_fifo #(
      .DEPTH (DEPTH),
      .DW    (PW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata ({in_x, in_y}),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         wcnt      <= '0;
         mul_start <= 1'b0;
         mul_x     <= '0;
         mul_y     <= '0;
         out_valid <= 1'b0;
         out_z     <= '0;
         out_err   <= 1'b0;
      end else begin
         mul_start <= 1'b0;
         case (state)
            IDLE: begin
               if (!empty) begin
                  mul_x     <= head[PW-1:WIDTH];
                  mul_y     <= head[WIDTH-1:0];
                  mul_start <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               wcnt  <= '0;
               state <= WAIT;
            end
            WAIT: begin
               wcnt <= wcnt + 1'b1;
               // First WAIT cycle ignores mul_valid: it may still be the previous operation's level.
               if ((wcnt != '0) && mul_valid) begin
                  out_z     <= mul_z;
                  out_err   <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end else if (wcnt == WLAST) begin
                  out_z     <= '0;
                  out_err   <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_dispatch.sv
// tb/tb_mul_dispatch.sv - self-checking bench for mul_dispatch with a latency-programmable mul model
module tb_mul_dispatch;

   localparam int TIMEOUT = 32;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_x = 8'h0;
   logic [7:0]  in_y = 8'h0;
   logic        mul_start;
   logic [7:0]  mul_x;
   logic [7:0]  mul_y;
   logic [15:0] mul_z;
   logic        mul_valid;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_z;
   logic        out_err;

   logic        model_valid = 1'b0;
   logic [15:0] model_z = 16'h0;
   logic [15:0] model_prod = 16'h0;
   logic        force_valid = 1'b0;
   logic [15:0] force_z = 16'h0;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int pend = 0;
   int mk;
   int ma;
   int mb;
   logic ov_prev = 1'b0;

   int          st_cyc[$];
   logic [7:0]  st_x[$];
   logic [7:0]  st_y[$];
   int          rise_cyc[$];
   logic [15:0] res_z[$];
   logic        res_err[$];
   logic [15:0] exp_z[$];
   logic        exp_err[$];
   int          kq[$];

   assign mul_valid = model_valid | force_valid;
   assign mul_z     = force_valid ? force_z : model_z;

   mul_dispatch dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .mul_start (mul_start),
      .mul_x     (mul_x),
      .mul_y     (mul_y),
      .mul_z     (mul_z),
      .mul_valid (mul_valid),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_z     (out_z),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // mul model: each start consumes the next scheduled latency k; k==0 means it never answers
   always @(negedge clk) begin
      model_valid = 1'b0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            model_valid = 1'b1;
            model_z     = model_prod;
         end
      end
      if (mul_start && !reset) begin
         mk = (kq.size() > 0) ? kq.pop_front() : 0;
         if (mk > 0) begin
            ma         = int'($signed(mul_x));
            mb         = int'($signed(mul_y));
            model_prod = 16'(ma * mb);
            pend       = mk;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (mul_start) begin
            st_cyc.push_back(cyc);
            st_x.push_back(mul_x);
            st_y.push_back(mul_y);
         end
         if (out_valid && !ov_prev) rise_cyc.push_back(cyc);
         if (out_valid && out_ready) begin
            res_z.push_back(out_z);
            res_err.push_back(out_err);
         end
      end
      ov_prev = out_valid;
   end

   initial begin
      #2000000;
      $display("FAIL global_watchdog: simulation did not complete, got cycle %0d, want finish", cyc);
      $fatal(1);
   end

   task automatic clear_logs();
      st_cyc.delete(); st_x.delete(); st_y.delete(); rise_cyc.delete();
      res_z.delete(); res_err.delete(); exp_z.delete(); exp_err.delete(); kq.delete();
   endtask

   task automatic push_pair(input logic [7:0] x, input logic [7:0] y, input int k, output int acc);
      int n = 0;
      acc = -1;
      in_valid = 1'b1;
      in_x = x;
      in_y = y;
      while (acc < 0 && n < 400) begin
         if (in_ready) begin
            @(posedge clk); #1;
            acc = cyc;
         end else begin
            @(negedge clk);
            n++;
         end
      end
      in_valid = 1'b0;
      if (acc >= 0) begin
         exp_z.push_back(k == 0 ? 16'h0 : 16'(int'($signed(x)) * int'($signed(y))));
         exp_err.push_back(k == 0);
         kq.push_back(k);
      end else begin
         vectors++; miscompares++;
         $display("FAIL push_accept: in_ready stayed %b, want 1 within 400 cycles", in_ready);
      end
   endtask

   task automatic wait_results(input int n, input int budget, output bit ok);
      int c = 0;
      while (res_z.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      ok = (res_z.size() >= n);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({in_ready, mul_start, mul_x, mul_y, out_valid, out_z, out_err} !== {1'b1, 1'b0, 8'h0, 8'h0, 1'b0, 16'h0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_values: got rdy=%b st=%b x=%h y=%h ov=%b z=%h err=%b, want 1 0 00 00 0 0000 0",
                  in_ready, mul_start, mul_x, mul_y, out_valid, out_z, out_err);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({in_ready, mul_start, out_valid} !== 3'b100) begin
         miscompares++;
         $display("FAIL post_reset_idle: got rdy=%b st=%b ov=%b, want 1 0 0", in_ready, mul_start, out_valid);
      end
   endtask

   task automatic test_single();
      int acc;
      bit ok;
      clear_logs();
      out_ready = 1'b1;
      push_pair(8'd5, 8'd3, 9, acc);
      wait_results(1, 80, ok);
      repeat (5) @(negedge clk);
      vectors++;
      if (!ok) begin
         miscompares++; $display("FAIL single_done: got %0d results, want 1", res_z.size());
      end
      vectors++;
      if (st_cyc.size() !== 1) begin
         miscompares++; $display("FAIL single_start_count: got %0d, want 1", st_cyc.size());
      end
      if (st_cyc.size() > 0) begin
         vectors++;
         if (st_cyc[0] !== acc + 1 || st_x[0] !== 8'd5 || st_y[0] !== 8'd3) begin
            miscompares++;
            $display("FAIL single_issue: got cyc=%0d x=%0d y=%0d, want cyc=%0d x=5 y=3", st_cyc[0], st_x[0], st_y[0], acc + 1);
         end
      end
      if (ok && rise_cyc.size() > 0) begin
         vectors++;
         if (res_z[0] !== exp_z[0] || res_err[0] !== exp_err[0] || rise_cyc[0] !== st_cyc[0] + 10) begin
            miscompares++;
            $display("FAIL single_result: got z=%h err=%b rise=%0d, want z=%h err=%b rise=%0d",
                     res_z[0], res_err[0], rise_cyc[0], exp_z[0], exp_err[0], st_cyc[0] + 10);
         end
      end
   endtask

   task automatic test_back_to_back();
      int acc;
      int k;
      bit ok;
      clear_logs();
      out_ready = 1'b1;
      k = $urandom_range(2, 7);
      push_pair(8'h80, 8'h01, k, acc);
      push_pair(8'h64, 8'hFF, k, acc);
      push_pair(8'hF9, 8'hF9, k, acc);
      wait_results(3, 200, ok);
      vectors++;
      if (!ok) begin
         miscompares++; $display("FAIL btb_done: got %0d results, want 3", res_z.size());
      end
      for (int i = 0; i < 3; i++) begin
         if (i < res_z.size()) begin
            vectors++;
            if (res_z[i] !== exp_z[i] || res_err[i] !== exp_err[i]) begin
               miscompares++;
               $display("FAIL btb_result[%0d]: got z=%h err=%b, want z=%h err=%b", i, res_z[i], res_err[i], exp_z[i], exp_err[i]);
            end
         end
      end
      for (int i = 1; i < 3; i++) begin
         if (i < rise_cyc.size()) begin
            vectors++;
            if (rise_cyc[i] - rise_cyc[i-1] !== k + 3) begin
               miscompares++;
               $display("FAIL btb_spacing[%0d]: got %0d cycles, want %0d", i, rise_cyc[i] - rise_cyc[i-1], k + 3);
            end
         end
      end
   endtask

   task automatic test_fifo_full();
      int acc;
      int acc5;
      int n = 0;
      bit ok;
      clear_logs();
      out_ready = 1'b1;
      push_pair(8'd11, 8'd2, 0, acc);
      while (st_cyc.size() < 1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (st_cyc.size() < 1) begin
         miscompares++; $display("FAIL fifo_first_issue: got %0d starts, want 1", st_cyc.size());
      end
      for (int i = 0; i < 4; i++) push_pair(8'($urandom), 8'($urandom), 3, acc);
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++; $display("FAIL fifo_full_ready: got in_ready=%b, want 0", in_ready);
      end
      push_pair(8'($urandom), 8'($urandom), 3, acc5);
      wait_results(6, 400, ok);
      vectors++;
      if (!ok) begin
         miscompares++; $display("FAIL fifo_done: got %0d results, want 6", res_z.size());
      end
      if (st_cyc.size() > 1) begin
         vectors++;
         if (acc5 !== st_cyc[1] + 1) begin
            miscompares++; $display("FAIL fifo_fifth_accept: got cyc %0d, want %0d", acc5, st_cyc[1] + 1);
         end
      end
      for (int i = 0; i < 6; i++) begin
         if (i < res_z.size()) begin
            vectors++;
            if (res_z[i] !== exp_z[i] || res_err[i] !== exp_err[i]) begin
               miscompares++;
               $display("FAIL fifo_result[%0d]: got z=%h err=%b, want z=%h err=%b", i, res_z[i], res_err[i], exp_z[i], exp_err[i]);
            end
         end
      end
   endtask

   task automatic test_hold_stall();
      int acc;
      int h;
      int n = 0;
      bit ok;
      clear_logs();
      out_ready = 1'b0;
      push_pair(8'($urandom), 8'($urandom), 4, acc);
      push_pair(8'($urandom), 8'($urandom), 4, acc);
      while (!out_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vectors++;
         if ({out_valid, out_err, out_z} !== {1'b1, exp_err[0], exp_z[0]}) begin
            miscompares++;
            $display("FAIL hold_stable[%0d]: got ov=%b err=%b z=%h, want ov=1 err=%b z=%h", i, out_valid, out_err, out_z, exp_err[0], exp_z[0]);
         end
      end
      vectors++;
      if (st_cyc.size() !== 1) begin
         miscompares++; $display("FAIL hold_no_issue: got %0d starts, want 1", st_cyc.size());
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      h = cyc;
      wait_results(2, 80, ok);
      vectors++;
      if (!ok || st_cyc.size() < 2) begin
         miscompares++; $display("FAIL hold_done: got %0d results %0d starts, want 2 2", res_z.size(), st_cyc.size());
      end else begin
         vectors++;
         if (st_cyc[1] !== h + 1) begin
            miscompares++; $display("FAIL hold_resume: got start cyc %0d, want %0d", st_cyc[1], h + 1);
         end
         vectors++;
         if (res_z[1] !== exp_z[1] || res_err[1] !== exp_err[1]) begin
            miscompares++; $display("FAIL hold_second: got z=%h err=%b, want z=%h err=%b", res_z[1], res_err[1], exp_z[1], exp_err[1]);
         end
      end
   endtask

   task automatic test_stale_valid();
      int acc;
      bit ok;
      clear_logs();
      out_ready = 1'b1;
      force_z = 16'hDEAD;
      force_valid = 1'b1;
      push_pair(8'($urandom), 8'($urandom), 9, acc);
      repeat (3) @(posedge clk);
      #1;
      force_valid = 1'b0;
      wait_results(1, 80, ok);
      vectors++;
      if (!ok || rise_cyc.size() < 1 || st_cyc.size() < 1) begin
         miscompares++; $display("FAIL stale_done: got %0d results, want 1", res_z.size());
      end else begin
         vectors++;
         if (res_z[0] !== exp_z[0] || res_err[0] !== 1'b0 || rise_cyc[0] !== st_cyc[0] + 10) begin
            miscompares++;
            $display("FAIL stale_capture: got z=%h err=%b rise=%0d, want z=%h err=0 rise=%0d",
                     res_z[0], res_err[0], rise_cyc[0], exp_z[0], st_cyc[0] + 10);
         end
      end
   endtask

   task automatic test_timeout();
      int acc;
      int k;
      bit ok;
      clear_logs();
      out_ready = 1'b1;
      k = $urandom_range(2, 10);
      push_pair(8'($urandom), 8'($urandom), 0, acc);
      push_pair(8'($urandom), 8'($urandom), k, acc);
      wait_results(2, 200, ok);
      vectors++;
      if (!ok || rise_cyc.size() < 2 || st_cyc.size() < 2) begin
         miscompares++; $display("FAIL timeout_done: got %0d results, want 2", res_z.size());
      end else begin
         vectors++;
         if (res_z[0] !== 16'h0 || res_err[0] !== 1'b1 || rise_cyc[0] !== st_cyc[0] + TIMEOUT + 1) begin
            miscompares++;
            $display("FAIL timeout_err: got z=%h err=%b rise=%0d, want z=0000 err=1 rise=%0d",
                     res_z[0], res_err[0], rise_cyc[0], st_cyc[0] + TIMEOUT + 1);
         end
         vectors++;
         if (res_z[1] !== exp_z[1] || res_err[1] !== 1'b0 || rise_cyc[1] - rise_cyc[0] !== k + 3) begin
            miscompares++;
            $display("FAIL timeout_next: got z=%h err=%b gap=%0d, want z=%h err=0 gap=%0d",
                     res_z[1], res_err[1], rise_cyc[1] - rise_cyc[0], exp_z[1], k + 3);
         end
      end
   endtask

   task automatic test_random();
      bit ok;
      clear_logs();
      fork
         begin
            int acc;
            for (int i = 0; i < 24; i++) begin
               repeat ($urandom_range(0, 3)) begin
                  @(posedge clk); #1;
               end
               push_pair(8'($urandom), 8'($urandom), $urandom_range(2, 12), acc);
            end
         end
         begin
            for (int i = 0; i < 600; i++) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      wait_results(24, 400, ok);
      vectors++;
      if (!ok) begin
         miscompares++; $display("FAIL random_done: got %0d results, want 24", res_z.size());
      end
      for (int i = 0; i < 24; i++) begin
         if (i < res_z.size()) begin
            vectors++;
            if (res_z[i] !== exp_z[i] || res_err[i] !== exp_err[i]) begin
               miscompares++;
               $display("FAIL random_result[%0d]: got z=%h err=%b, want z=%h err=%b", i, res_z[i], res_err[i], exp_z[i], exp_err[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      int acc;
      int n = 0;
      clear_logs();
      out_ready = 1'b1;
      push_pair(8'($urandom), 8'($urandom), 6, acc);
      push_pair(8'($urandom), 8'($urandom), 6, acc);
      while (st_cyc.size() < 1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      repeat (2) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      kq.delete();
      for (int i = 0; i < 30; i++) begin
         if (i == 8) begin
            force_z = 16'hBEEF;
            force_valid = 1'b1;
         end
         if (i == 10) force_valid = 1'b0;
         @(negedge clk);
         vectors++;
         if ({in_ready, mul_start, mul_x, mul_y, out_valid, out_z, out_err} !== {1'b1, 1'b0, 8'h0, 8'h0, 1'b0, 16'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid_wait[%0d]: got rdy=%b st=%b x=%h y=%h ov=%b z=%h err=%b, want 1 0 00 00 0 0000 0",
                     i, in_ready, mul_start, mul_x, mul_y, out_valid, out_z, out_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_fifo_full();
      test_hold_stall();
      test_stale_valid();
      test_timeout();
      test_random();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
